// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t  : sequencer FSM state encoding
//   INSTR_BYTES    : PC increment for sequential fetch
//   is_misaligned  : true when the low address bits are not word-aligned
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EXEC = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Only the two low bits decide word alignment, so callers pass addr[1:0].
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_retire_counter.sv
// Retired-instruction counter: CNT_W-bit up-counter, wraps modulo 2^CNT_W.
//   clk, rstn : clock, asynchronous active-low reset
//   en        : count one retired instruction this cycle
//   count     : current count
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/execute sequencer. Reads the instruction at pc_q, loads it
// into the external IR, hands off to execute, then writes PC+4 or a redirect
// target into the external PC register.
//   clk, rstn                      : clock, asynchronous active-low reset
//   run                            : permits new fetches (level)
//   pc_q                           : current PC register value
//   pc_wr/pc_next, ir_wr/ir_next   : PC and IR register write ports
//   mem_req/mem_addr/mem_gnt       : instruction read request handshake
//   mem_rvalid/mem_rdata           : instruction read return
//   exec_start/exec_done           : execute stage handoff
//   redirect/redirect_pc           : taken branch target, qualified by exec_done
//   flush/flush_pc                 : trap/flush pulse and its target
//   fault                          : sticky misaligned-target fault
//   busy                           : sequencer not idle
//   instret                        : retired-instruction count
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no activity, waits for run
// REQ   | read request at pc_q held until granted
// WAIT  | request accepted, waiting for data (dropped when discard=1)
// EXEC  | IR valid, execute in progress until exec_done
// HALT  | misaligned target seen, fault held until reset
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic [XLEN-1:0]  pc_q,
    output logic             pc_wr,
    output logic [XLEN-1:0]  pc_next,
    output logic             ir_wr,
    output logic [XLEN-1:0]  ir_next,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             exec_start,
    input  logic             exec_done,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             flush,
    input  logic [XLEN-1:0]  flush_pc,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] instret
);

    fetch_state_t    state, state_nxt;
    logic            discard, discard_nxt;
    logic            fault_set;
    logic            retire;
    logic [XLEN-1:0] target;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            discard    <= 1'b0;
            fault      <= 1'b0;
            exec_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            discard    <= discard_nxt;
            exec_start <= (state == WAIT) && (state_nxt == EXEC);
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    assign target   = redirect ? redirect_pc : pc_q + XLEN'(INSTR_BYTES);
    assign mem_req  = (state == REQ);
    assign mem_addr = (state == REQ) ? pc_q : '0;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        pc_wr       = 1'b0;
        pc_next     = '0;
        ir_wr       = 1'b0;
        ir_next     = '0;
        retire      = 1'b0;
        fault_set   = 1'b0;

        if (flush && state != HALT) begin
            if (is_misaligned(flush_pc[1:0])) begin
                fault_set   = 1'b1;
                discard_nxt = 1'b0;
                state_nxt   = HALT;
            end else begin
                pc_wr   = 1'b1;
                pc_next = flush_pc;
                case (state)
                    // A grant in the flush cycle leaves a read in flight
                    // whose data must be thrown away.
                    REQ: begin
                        if (mem_gnt) begin
                            state_nxt   = WAIT;
                            discard_nxt = 1'b1;
                        end else begin
                            state_nxt   = REQ;
                        end
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            state_nxt   = REQ;
                            discard_nxt = 1'b0;
                        end else begin
                            discard_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = REQ;
                endcase
            end
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = REQ;
                        end else begin
                            ir_wr     = 1'b1;
                            ir_next   = mem_rdata;
                            state_nxt = EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (is_misaligned(target[1:0])) begin
                            fault_set = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            pc_wr     = 1'b1;
                            pc_next   = target;
                            retire    = 1'b1;
                            state_nxt = run ? REQ : IDLE;
                        end
                    end
                end
                default: state_nxt = HALT;
            endcase
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk   (clk),
        .rstn  (rstn),
        .en    (retire),
        .count (instret)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an external PC register model and
// scoreboards for IR loads and PC updates. Built with CNT_W=4 so the
// retired-instruction counter wraps within a short run.
module tb_fetch_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             run;
    logic [XLEN-1:0]  pc_q;
    logic             pc_wr;
    logic [XLEN-1:0]  pc_next;
    logic             ir_wr;
    logic [XLEN-1:0]  ir_next;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    logic             exec_start;
    logic             exec_done;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [XLEN-1:0]  flush_pc;
    logic             fault;
    logic             busy;
    logic [CNT_W-1:0] instret;

    fetch_sequencer #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run         (run),
        .pc_q        (pc_q),
        .pc_wr       (pc_wr),
        .pc_next     (pc_next),
        .ir_wr       (ir_wr),
        .ir_next     (ir_next),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fault       (fault),
        .busy        (busy),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // External PC register, with a bench-side load port for preset values.
    logic            pc_ld;
    logic [XLEN-1:0] pc_ld_val;
    always @(posedge clk) begin
        if (pc_ld) pc_q <= pc_ld_val;
        else if (pc_wr) pc_q <= pc_next;
    end

    int ir_wr_cnt = 0;
    always @(posedge clk) begin
        if (rstn && ir_wr) ir_wr_cnt <= ir_wr_cnt + 1;
    end

    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_fetch = 0;
    logic [XLEN-1:0]  exp_pc;
    logic [CNT_W-1:0] exp_instret;
    logic [XLEN-1:0]  ir_exp[$];
    logic [XLEN-1:0]  pc_exp[$];

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected summary before 100000ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic load_pc(input logic [XLEN-1:0] v);
        pc_ld     = 1'b1;
        pc_ld_val = v;
        cyc();
        pc_ld     = 1'b0;
    endtask

    task automatic pop_ir();
        logic [XLEN-1:0] e;
        chk("ir_sb_nonempty", 64'(ir_exp.size() != 0), 1);
        if (ir_exp.size() != 0) begin
            e = ir_exp.pop_front();
            chk("ir_next", ir_next, e);
        end
    endtask

    task automatic pop_pc();
        logic [XLEN-1:0] e;
        chk("pc_sb_nonempty", 64'(pc_exp.size() != 0), 1);
        if (pc_exp.size() != 0) begin
            e = pc_exp.pop_front();
            chk("pc_next", pc_next, e);
        end
    endtask

    // Starts at the drive point of a REQ cycle, ends at the first EXEC cycle.
    task automatic do_fetch(input logic [XLEN-1:0] word, input int gnt_wait,
                            input int rv_wait, input logic [XLEN-1:0] addr);
        mem_gnt = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            settle();
            chk("bp_req", mem_req, 1);
            chk("bp_addr", mem_addr, addr);
            chk("bp_no_start", exec_start, 0);
            cyc();
        end
        mem_gnt = 1'b1;
        settle();
        chk("req", mem_req, 1);
        chk("req_addr", mem_addr, addr);
        cyc();
        mem_gnt = 1'b0;
        ir_exp.push_back(word);
        n_fetch++;
        for (int i = 0; i < rv_wait; i++) begin
            mem_rdata = $urandom;
            settle();
            chk("wait_no_req", mem_req, 0);
            chk("wait_no_irwr", ir_wr, 0);
            chk("wait_no_start", exec_start, 0);
            cyc();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        settle();
        chk("ir_wr", ir_wr, 1);
        pop_ir();
        cyc();
        mem_rvalid = 1'b0;
    endtask

    // Starts at the first EXEC cycle, ends one cycle after exec_done.
    task automatic do_exec(input int done_wait, input logic redir,
                           input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] exp_next);
        pc_exp.push_back(exp_next);
        for (int i = 0; i <= done_wait; i++) begin
            exec_done   = (i == done_wait);
            redirect    = redir;
            redirect_pc = rpc;
            settle();
            chk("exec_start", exec_start, 64'(i == 0));
            if (i < done_wait) begin
                chk("exec_hold_pcwr", pc_wr, 0);
                cyc();
            end
        end
        chk("pc_wr", pc_wr, 1);
        pop_pc();
        cyc();
        exec_done   = 1'b0;
        redirect    = 1'b0;
        exp_instret = exp_instret + 1'b1;
        exp_pc      = exp_next;
        chk("instret", instret, exp_instret);
        chk("loop_req", mem_req, run);
        chk("busy_after_exec", busy, run);
    endtask

    initial begin
        rstn = 1'b0; run = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exec_done = 1'b0; redirect = 1'b0; redirect_pc = '0; flush = 1'b0; flush_pc = '0;
        pc_ld = 1'b1; pc_ld_val = 32'h100; exp_instret = '0; exp_pc = 32'h100;
        cyc();
        pc_ld = 1'b0;
        settle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pc_wr", pc_wr, 0);
        chk("rst_pc_next", pc_next, 0);
        chk("rst_ir_wr", ir_wr, 0);
        chk("rst_ir_next", ir_next, 0);
        chk("rst_exec_start", exec_start, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instret", instret, 0);
        cyc();
        rstn = 1'b1;
        run  = 1'b1;
        settle();
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
        cyc();

        // zero-wait memory, done on the exec_start cycle
        do_fetch(32'h0050_0093, 0, 0, exp_pc);
        do_exec(0, 1'b0, '0, 32'h104);

        // backpressure on grant and data, then a redirect
        do_fetch(32'h00a0_0113, 4, 3, exp_pc);
        do_exec(2, 1'b1, 32'h200, 32'h200);

        // flush while waiting on 0x100; the stale word must not load IR
        load_pc(32'h100);
        mem_gnt = 1'b1;
        settle();
        chk("flushw_addr", mem_addr, 32'h100);
        cyc();
        mem_gnt  = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h80;
        settle();
        chk("flushw_pc_wr", pc_wr, 1);
        chk("flushw_pc_next", pc_next, 32'h80);
        chk("flushw_ir_wr", ir_wr, 0);
        cyc();
        flush      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hdead_beef;
        settle();
        chk("stale_ir_wr", ir_wr, 0);
        chk("stale_pc_wr", pc_wr, 0);
        cyc();
        mem_rvalid = 1'b0;
        exp_pc = 32'h80;
        settle();
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 32'h80);
        cyc();
        do_fetch(32'h0010_0193, 0, 1, exp_pc);
        do_exec(0, 1'b0, '0, 32'h84);

        // flush coinciding with exec_done wins and retires nothing
        do_fetch(32'h0020_0213, 1, 0, exp_pc);
        exec_done = 1'b1;
        flush     = 1'b1;
        flush_pc  = 32'h300;
        settle();
        chk("fx_start", exec_start, 1);
        chk("fx_pc_wr", pc_wr, 1);
        chk("fx_pc_next", pc_next, 32'h300);
        cyc();
        exec_done = 1'b0;
        flush     = 1'b0;
        chk("fx_instret", instret, exp_instret);
        exp_pc = 32'h300;
        settle();
        chk("fx_req", mem_req, 1);
        chk("fx_addr", mem_addr, 32'h300);
        cyc();

        // PC+4 wrap, with run dropped during the fetch
        load_pc(32'hffff_fffc);
        exp_pc = 32'hffff_fffc;
        run = 1'b0;
        do_fetch(32'h0030_0293, 1, 0, exp_pc);
        do_exec(1, 1'b0, '0, 32'h0);
        settle();
        chk("idle_hold_busy", busy, 0);
        cyc();
        run = 1'b1;
        cyc();

        // retire enough to wrap the 4-bit counter back to zero
        for (int k = 0; k < 12; k++) begin
            logic [XLEN-1:0] w;
            logic [XLEN-1:0] tgt;
            logic            rd;
            w   = $urandom;
            rd  = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hffff_fffc;
            do_fetch(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), exp_pc);
            do_exec(int'($urandom_range(0, 1)), rd, tgt, rd ? tgt : exp_pc + 32'd4);
        end
        chk("instret_wrap", instret, 4'd0);

        // misaligned redirect -> fault, HALT, nothing written or retired
        do_fetch(32'h0040_0313, 0, 0, exp_pc);
        exec_done   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        settle();
        chk("mis_start", exec_start, 1);
        chk("mis_pc_wr", pc_wr, 0);
        cyc();
        exec_done = 1'b0;
        redirect  = 1'b0;
        chk("mis_fault", fault, 1);
        chk("mis_instret", instret, exp_instret);
        settle();
        chk("halt_req", mem_req, 0);
        chk("halt_busy", busy, 1);
        cyc();
        flush    = 1'b1;
        flush_pc = 32'h400;
        settle();
        chk("halt_flush_pc_wr", pc_wr, 0);
        cyc();
        flush = 1'b0;
        settle();
        chk("halt_fault_held", fault, 1);
        chk("halt_req_held", mem_req, 0);
        cyc();
        rstn = 1'b0;
        settle();
        chk("rst_clears_fault", fault, 0);
        cyc();
        rstn = 1'b1;

        // async reset in WAIT between edges, then a stale rvalid
        load_pc(32'h100);
        mem_gnt = 1'b1;
        settle();
        chk("w_rst_addr", mem_addr, 32'h100);
        cyc();
        mem_gnt = 1'b0;
        #2;
        chk("w_pre_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("w_rst_busy", busy, 0);
        chk("w_rst_req", mem_req, 0);
        chk("w_rst_addr0", mem_addr, 0);
        chk("w_rst_pc_wr", pc_wr, 0);
        chk("w_rst_ir_wr", ir_wr, 0);
        chk("w_rst_instret", instret, 0);
        cyc();
        rstn       = 1'b1;
        run        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        settle();
        chk("post_rst_ir_wr", ir_wr, 0);
        chk("post_rst_ir_next", ir_next, 0);
        cyc();
        mem_rvalid = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("ir_wr_count", ir_wr_cnt, n_fetch);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
